// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file: frame field widths,
// command encoding and the frame decoder state type.
package spi_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned ADDR_W = 8;

    localparam int unsigned         CMD_WR_BIT    = 0;
    localparam logic [CMD_W-1:0]    CMD_RSVD_MASK = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StSkip
    } spi_state_e;

    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
        return (cmd & CMD_RSVD_MASK) == '0;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with a history flop to
// produce single-cycle rise and fall strobes in the clk_i domain.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       hist_q;

    // Reset to 0 so a frame already in flight at reset release shows no cs edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            hist_q <= sync_q[1];
        end
    end

    assign sync_o = sync_q[1];
    assign rise_o = sync_q[1] & ~hist_q;
    assign fall_o = ~sync_q[1] & hist_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// Oversampled SPI mode-0 slave: decodes cmd/addr/data frames into a small
// flop-based register file, with a host-side registered read port.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    input  logic [DEPTH_LOG2-1:0] host_addr_i,
    output logic [DATA_W-1:0]     host_rdata_o,
    output logic                  frame_done_o,
    output logic                  frame_err_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic mosi_s;
    logic unused_sclk_level, unused_cs_level;
    logic unused_mosi_rise, unused_mosi_fall;
    logic unused_rx_msb;

    spi_sync_edge u_sync_sclk (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (spi_clk_i),
        .sync_o  (unused_sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (spi_cs_n_i),
        .sync_o  (unused_cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (spi_mosi_i),
        .sync_o  (mosi_s),
        .rise_o  (unused_mosi_rise),
        .fall_o  (unused_mosi_fall)
    );

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       rx_q, rx_d;
    logic [DATA_W-1:0]       rx_next;
    logic [DATA_W-1:0]       tx_q, tx_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    is_wr_q, is_wr_d;
    logic                    complete_q, complete_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    reg_we;
    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [DATA_W-1:0]       host_rdata_q;

    assign rx_next       = {rx_q[DATA_W-2:0], mosi_s};
    assign unused_rx_msb = rx_q[DATA_W-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        idx_d      = idx_q;
        is_wr_d    = is_wr_q;
        complete_d = complete_q;
        err_d      = err_q;
        done_d     = 1'b0;
        reg_we     = 1'b0;

        if (cs_rise) begin
            // cs rising takes priority over any coincident sclk strobe.
            if (state_q != StIdle) begin
                state_d = StIdle;
                if (state_q == StSkip && complete_q) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d    = StCmd;
                        cnt_d      = '0;
                        complete_d = 1'b0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CMD_LAST) begin
                            cnt_d = '0;
                            if (cmd_is_legal(rx_next[CMD_W-1:0])) begin
                                is_wr_d = rx_next[CMD_WR_BIT];
                                state_d = StAddr;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StSkip;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            idx_d   = rx_next[DEPTH_LOG2-1:0];
                            state_d = StData;
                            if (!is_wr_q) begin
                                tx_d = regs_q[rx_next[DEPTH_LOG2-1:0]];
                            end
                        end
                    end
                end
                StData: begin
                    if (sclk_rise) begin
                        if (is_wr_q) begin
                            rx_d = rx_next;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            reg_we     = is_wr_q;
                            complete_d = 1'b1;
                            state_d    = StSkip;
                        end
                    end else if (sclk_fall && !is_wr_q && cnt_q != '0) begin
                        // The fall before the first data rise must keep the MSB in place.
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
                StSkip: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            idx_q      <= idx_d;
            is_wr_q    <= is_wr_d;
            complete_q <= complete_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Host read samples the pre-commit value when both hit the same index.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            host_rdata_q <= '0;
        end else begin
            if (reg_we) begin
                regs_q[idx_q] <= rx_next;
            end
            host_rdata_q <= regs_q[host_addr_i];
        end
    end

    assign spi_miso_o   = (state_q == StData) && !is_wr_q && tx_q[DATA_W-1];
    assign host_rdata_o = host_rdata_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench: a behavioural SPI mode-0 master drives frames while a
// reference register model and an expectation queue score the slave.
module tb_spi_slave_regfile;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sclk = 1'b0;
    logic                  cs_n = 1'b1;
    logic                  mosi = 1'b0;
    logic                  miso;
    logic [DEPTH_LOG2-1:0] host_addr = '0;
    logic [DATA_W-1:0]     host_rdata;
    logic                  frame_done;
    logic                  frame_err;

    spi_slave_regfile #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .spi_clk_i    (sclk),
        .spi_cs_n_i   (cs_n),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .host_addr_i  (host_addr),
        .host_rdata_o (host_rdata),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic        miso_seen = 1'b0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (miso === 1'b1) miso_seen = 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin;
        cs_n = 1'b0;
        cycles(4);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            cycles(4);
            cap[i] = miso;
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input int gap);
        cycles(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        cycles(gap);
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [15:0] data, input int nbits, input int gap,
                             output logic [15:0] rd);
        logic [31:0] cap;
        logic [31:0] dv;
        spi_begin();
        spi_bits({24'h0, cmd}, 8, cap);
        spi_bits({24'h0, addr}, 8, cap);
        dv = {16'h0, data};
        if (nbits < 16) dv = dv >> (16 - nbits);
        spi_bits(dv, nbits, cap);
        rd = cap[15:0];
        spi_end(gap);
    endtask

    task automatic peek(input int idx, output logic [15:0] v);
        host_addr = idx[DEPTH_LOG2-1:0];
        cycles(2);
        v = host_rdata;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        rst_n = 1'b0;
        cycles(3);
        total++;
        if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        rst_n = 1'b1;
        cycles(2);
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            peek(i, v);
            total++;
            if (v !== 16'h0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0000", i, v); end
        end
    endtask

    task automatic test_write;
        logic [31:0] cap;
        logic [15:0] v;
        exp_t        e;
        int          d0;
        int          waited;
        d0 = done_cnt;
        host_addr = 4'd11;
        model[11] = 16'hA001;
        exp_q.push_back('{idx: 11, val: 16'hA001});
        spi_begin();
        spi_bits(32'h0B, 8, cap);
        spi_bits(32'h0B, 8, cap);
        spi_bits(32'h0000_5000, 15, cap);  // top 15 bits of 0xA001
        mosi = 1'b1;
        cycles(4);
        sclk = 1'b1;
        cycles(1);
        total++;
        if (host_rdata !== 16'h0) begin bad++; $display("FAIL write_early got=%h exp=0000", host_rdata); end
        waited = 1;
        while (host_rdata !== 16'hA001 && waited < 8) begin
            cycles(1);
            waited++;
        end
        e = exp_q.pop_front();
        total++;
        if (host_rdata !== e.val) begin
            bad++; $display("FAIL write_commit got=%h exp=%h", host_rdata, e.val);
        end
        cycles(8 - waited);
        sclk = 1'b0;
        spi_end(6);
        peek(e.idx, v);
        total++;
        if (v !== e.val) begin bad++; $display("FAIL write_host got=%h exp=%h", v, e.val); end
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL write_done got=%0d exp=%0d", done_cnt, d0 + 1); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL write_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_read;
        logic [15:0] rd;
        logic [15:0] v;
        exp_t        e;
        int          d0;
        d0 = done_cnt;
        exp_q.push_back('{idx: 11, val: model[11]});
        spi_frame(8'h0A, 8'h0B, 16'h0000, 16, 6, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e.val) begin bad++; $display("FAIL read_miso got=%h exp=%h", rd, e.val); end
        peek(e.idx, v);
        total++;
        if (v !== model[11]) begin bad++; $display("FAIL read_unchanged got=%h exp=%h", v, model[11]); end
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL read_done got=%0d exp=%0d", done_cnt, d0 + 1); end
        total++;
        if (miso !== 1'b0) begin bad++; $display("FAIL read_miso_idle got=%b exp=0", miso); end
    endtask

    task automatic test_truncated;
        logic [15:0] rd;
        logic [15:0] v;
        exp_t        e;
        int          d0;
        d0 = done_cnt;
        spi_frame(8'h01, 8'h03, 16'hFFFF, 10, 6, rd);
        total++;
        if (frame_err !== 1'b1) begin bad++; $display("FAIL trunc_err got=%b exp=1", frame_err); end
        total++;
        if (done_cnt !== d0) begin bad++; $display("FAIL trunc_done got=%0d exp=%0d", done_cnt, d0); end
        peek(3, v);
        total++;
        if (v !== model[3]) begin bad++; $display("FAIL trunc_reg3 got=%h exp=%h", v, model[3]); end
        model[2] = 16'h5555;
        exp_q.push_back('{idx: 2, val: 16'h5555});
        spi_frame(8'h01, 8'h02, 16'h5555, 16, 6, rd);
        e = exp_q.pop_front();
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL trunc_clear got=%b exp=0", frame_err); end
        peek(e.idx, v);
        total++;
        if (v !== e.val) begin bad++; $display("FAIL trunc_recover got=%h exp=%h", v, e.val); end
    endtask

    task automatic test_illegal;
        logic [15:0] rd;
        logic [15:0] v;
        int          d0;
        d0 = done_cnt;
        miso_seen = 1'b0;
        spi_frame(8'h1B, 8'h0B, 16'h0F0F, 16, 6, rd);
        total++;
        if (frame_err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", frame_err); end
        total++;
        if (miso_seen !== 1'b0) begin bad++; $display("FAIL illegal_miso got=%b exp=0", miso_seen); end
        total++;
        if (done_cnt !== d0) begin bad++; $display("FAIL illegal_done got=%0d exp=%0d", done_cnt, d0); end
        for (int i = 0; i < DEPTH; i++) begin
            peek(i, v);
            total++;
            if (v !== model[i]) begin bad++; $display("FAIL illegal_reg%0d got=%h exp=%h", i, v, model[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] cap;
        logic [15:0] rd;
        logic [15:0] v;
        exp_t        e;
        int          d0;
        host_addr = 4'd11;
        spi_begin();
        spi_bits(32'h01, 8, cap);
        spi_bits(32'h0, 4, cap);
        rst_n = 1'b0;
        cycles(2);
        total++;
        if (host_rdata !== 16'h0) begin bad++; $display("FAIL rstmid_host got=%h exp=0000", host_rdata); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", frame_err); end
        total++;
        if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        d0 = done_cnt;
        spi_bits(32'h5, 4, cap);
        spi_bits(32'hBEEF, 16, cap);
        spi_end(6);
        total++;
        if (done_cnt !== d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cnt, d0); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_err2 got=%b exp=0", frame_err); end
        for (int i = 0; i < DEPTH; i++) begin
            peek(i, v);
            total++;
            if (v !== model[i]) begin bad++; $display("FAIL rstmid_reg%0d got=%h exp=%h", i, v, model[i]); end
        end
        model[5] = 16'h1234;
        exp_q.push_back('{idx: 5, val: 16'h1234});
        spi_frame(8'h01, 8'h05, 16'h1234, 16, 6, rd);
        e = exp_q.pop_front();
        peek(e.idx, v);
        total++;
        if (v !== e.val) begin bad++; $display("FAIL rstmid_write got=%h exp=%h", v, e.val); end
        total++;
        if (done_cnt !== d0 + 1) begin bad++; $display("FAIL rstmid_done2 got=%0d exp=%0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] rd;
        logic [15:0] v;
        exp_t        e;
        int          d0;
        d0 = done_cnt;
        model[0]  = 16'h0F0F;
        model[15] = 16'hBEEF;
        exp_q.push_back('{idx: 0, val: 16'h0F0F});
        exp_q.push_back('{idx: 15, val: 16'hBEEF});
        spi_frame(8'h01, 8'h00, 16'h0F0F, 16, 4, rd);
        spi_frame(8'h01, 8'h1F, 16'hBEEF, 16, 6, rd);
        total++;
        if (done_cnt !== d0 + 2) begin bad++; $display("FAIL b2b_done got=%0d exp=%0d", done_cnt, d0 + 2); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            peek(e.idx, v);
            total++;
            if (v !== e.val) begin bad++; $display("FAIL b2b_reg%0d got=%h exp=%h", e.idx, v, e.val); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            peek(i, v);
            total++;
            if (v !== model[i]) begin bad++; $display("FAIL b2b_all%0d got=%h exp=%h", i, v, model[i]); end
        end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_truncated();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
